// File: rtl/demux_1to3_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux_1to3_buf_pkg
// Shared constants and types for the 1-to-3 buffered distributor.
//   WIDTH    : datapath word width
//   SEL_W    : destination select code width
//   CNT_W    : drop counter width
//   NUM_DST  : number of destination slots
//   DST0..2  : legal destination codes (everything else is dropped)
//   slot_state_t : per-slot occupancy state
// -----------------------------------------------------------------------------
package demux_1to3_buf_pkg;

   localparam int WIDTH   = 32;
   localparam int SEL_W   = 3;
   localparam int CNT_W   = 8;
   localparam int NUM_DST = 3;

   localparam logic [2:0] DST0 = 3'd0;
   localparam logic [2:0] DST1 = 3'd1;
   localparam logic [2:0] DST2 = 3'd2;

   // EMPTY/FULL occupancy of one destination buffer.  The encoding is chosen
   // so that the state bit doubles as the slot's valid flag.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage : demux_1to3_buf_pkg

// File: rtl/demux_1to3_buf_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry output buffer with a valid/ack consumer handshake.
// Ports:
//   clk      in   rising-edge clock
//   clr      in   asynchronous active-low reset
//   load     in   write din into the buffer at this edge
//   din      in   WIDTH  word to store
//   ack      in   consumer takes dout this cycle (ignored while EMPTY)
//   dout     out  WIDTH  stored word; only changes on load, kept after ack
//   valid    out  slot is FULL (this is the slot's state, exposed directly)
//   can_load out  slot can take a word this cycle (empty, or draining now)
// -----------------------------------------------------------------------------
module demux_slot
   import demux_1to3_buf_pkg::*;
#(
   parameter int WIDTH = demux_1to3_buf_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ack,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             can_load
);

   slot_state_t state_q;
   slot_state_t state_d;
   logic        ack_eff;

   // An ack is only meaningful when there is something to take.
   assign ack_eff  = ack & (state_q == SLOT_FULL);
   assign valid    = (state_q == SLOT_FULL);
   // A slot draining this cycle can be refilled in the same cycle, so a
   // stream into one destination runs without bubbles.
   assign can_load = (state_q == SLOT_EMPTY) | ack_eff;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (load) state_d = SLOT_FULL;
         end
         SLOT_FULL: begin
            // A load wins over a simultaneous ack: the slot stays FULL
            // holding the new word.
            if (load)         state_d = SLOT_FULL;
            else if (ack_eff) state_d = SLOT_EMPTY;
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   // Data is not cleared on ack; it is only replaced by the next load.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         dout <= '0;
      end else if (load) begin
         dout <= din;
      end
   end

endmodule : demux_slot

// File: rtl/demux_1to3_buf.sv
// -----------------------------------------------------------------------------
// demux_1to3_buf
// Steers one producer word to one of three one-entry output buffers selected
// by sig.  Codes outside 0..2 are accepted immediately and dropped, and a
// saturating counter records how many were dropped.
//
// Handshakes:
//   producer side  - a word transfers on a cycle where in_valid & in_ready.
//                    in_ready is combinational and depends on sig, so the
//                    producer holds in_data/sig/in_valid until it transfers.
//                    When in_valid is low sig is don't-care.
//   consumer side  - out_valid[n] high means outN holds an unconsumed word;
//                    a word is consumed on a cycle where out_valid[n] &
//                    out_ack[n].  Acks to empty slots are ignored, and any
//                    combination of slots may be acked in one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   in_data    in   WIDTH  producer word
//   sig        in   SEL_W  destination code (0/1/2 legal)
//   in_valid   in   producer offers a word
//   in_ready   out  word accepted this cycle if offered
//   out0..2    out  WIDTH  buffered words per destination
//   out_valid  out  3  per-slot FULL flags
//   out_ack    in   3  per-slot consumer acks
//   drop_cnt   out  CNT_W  saturating count of dropped illegal-code words
// -----------------------------------------------------------------------------
module demux_1to3_buf
   import demux_1to3_buf_pkg::*;
#(
   parameter int WIDTH = demux_1to3_buf_pkg::WIDTH,
   parameter int SEL_W = demux_1to3_buf_pkg::SEL_W,
   parameter int CNT_W = demux_1to3_buf_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] sig,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ack,
   output logic [CNT_W-1:0] drop_cnt
);

   logic [NUM_DST-1:0] dst_hot;
   logic               legal;
   logic               accept;
   logic               drop;
   logic [NUM_DST-1:0] load;
   logic [NUM_DST-1:0] can_load;
   logic [WIDTH-1:0]   slot_dout [NUM_DST];

   // Select decode and ready mux.  Illegal codes are always ready because
   // they never need buffer space.
   always_comb begin
      dst_hot  = '0;
      legal    = 1'b0;
      in_ready = 1'b1;
      case (sig)
         SEL_W'(DST0): begin
            dst_hot[0] = 1'b1;
            legal      = 1'b1;
            in_ready   = can_load[0];
         end
         SEL_W'(DST1): begin
            dst_hot[1] = 1'b1;
            legal      = 1'b1;
            in_ready   = can_load[1];
         end
         SEL_W'(DST2): begin
            dst_hot[2] = 1'b1;
            legal      = 1'b1;
            in_ready   = can_load[2];
         end
         default: begin
            dst_hot  = '0;
            legal    = 1'b0;
            in_ready = 1'b1;
         end
      endcase
   end

   assign accept = in_valid & in_ready;
   assign load   = dst_hot & {NUM_DST{accept}};
   assign drop   = accept & ~legal;

   for (genvar n = 0; n < NUM_DST; n++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk      (clk),
         .clr      (clr),
         .load     (load[n]),
         .din      (in_data),
         .ack      (out_ack[n]),
         .dout     (slot_dout[n]),
         .valid    (out_valid[n]),
         .can_load (can_load[n])
      );
   end

   assign out0 = slot_dout[0];
   assign out1 = slot_dout[1];
   assign out2 = slot_dout[2];

   // Saturates at all-ones so a flood of bad codes cannot wrap back to a
   // small, misleading count.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule : demux_1to3_buf

// File: doc/demux_1to3_buf.md
Name: demux_1to3_buf

Overview:
- Bus-side distributor for the 32-bit datapath: takes one word plus a 3-bit destination select and delivers it to one of three buffered outputs.
- It is the receiving end of a 3-input select path. The producer drives a word and a `sig` code, and the block steers it to destination 0, 1 or 2.
- Each destination is a one-entry buffer with a valid/ack handshake, so consumers may take data later than the producer offers it.
- Illegal select codes are counted and dropped.

Parameters:
- WIDTH, 32, data word width.
- SEL_W, 3, select code width.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-low (0 = reset).
- in_data  in  WIDTH  word offered by the producer.
- sig  in  SEL_W  destination code; 0/1/2 are legal, 3..7 are illegal.
- in_valid  in  1  producer offers in_data/sig this cycle.
- in_ready  out  1  block accepts this cycle (combinational).
- out0  out  WIDTH  buffered word, destination 0.
- out1  out  WIDTH  buffered word, destination 1.
- out2  out  WIDTH  buffered word, destination 2.
- out_valid  out  3  bit n = slot n holds unconsumed data.
- out_ack  in  3  bit n = consumer n takes outN this cycle.
- drop_cnt  out  CNT_W  count of illegal-code words dropped.

Behaviour:
- Reset (clr=0, asynchronous assert, synchronous-safe deassert): out0/out1/out2=0, out_valid=3'b000, drop_cnt=0. Reset takes effect mid-transfer; a pending or held word is discarded.
- Slot state, per slot n: EMPTY (out_valid[n]=0) or FULL (out_valid[n]=1).
- Effective ack: ack_n = out_ack[n] & out_valid[n]. An ack to an EMPTY slot is ignored.
- in_ready:
  - sig in 0..2: in_ready = ~out_valid[sig] | ack_sig. A slot being drained in the same cycle can accept.
  - sig in 3..7: in_ready = 1.
- Accept: occurs when in_valid & in_ready.
  - Legal sig: the outN register loads in_data at the edge, and out_valid[sig]=1 the next cycle. Latency is 1 cycle from accept to data/valid visible.
  - Illegal sig: the word is dropped, no slot changes, and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1 with no wrap.
- Transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ack_n without a simultaneous accept.
  - FULL -> FULL on ack_n plus a simultaneous accept: the new word is loaded with no bubble.
  - FULL with no ack: the slot holds, and the producer stalls (in_ready=0 for that sig only).
- Hold rule: outN changes only on accept into slot n. A slot's data stays stable while FULL and not acked. Data is retained (not zeroed) after ack.
- Independence:
  - Slots not addressed by sig are unaffected except by their own acks.
  - Multiple out_ack bits may assert in one cycle, and each is honoured.
- When in_valid=0, no accept occurs and the value of sig is ignored.
- in_ready may change with sig in the same cycle. The producer must hold in_data/sig/in_valid stable until accepted.

Decomposition:
- Shared package (datapath constants):
  - WIDTH=32.
  - Destination codes DST0=3'd0, DST1=3'd1, DST2=3'd2.
  - Slot count NUM_DST=3.
- Sub-module demux_slot, instantiated 3×:
  - Ports: clk, clr, load, din, ack.
  - Outputs: dout, valid, can_load.
  - Contains the EMPTY/FULL state and the data register.
- Top level: select decode, in_ready mux, drop counter.

Test Plan:
- Reset: hold clr=0 for 3 cycles with random inputs -> out0..2=0, out_valid=000, drop_cnt=0. Assert clr mid-cycle -> outputs clear immediately, without waiting for a clock edge.
- Basic routing:
  - Send 0x0000_00AA sig=0, then 0x1234_5678 sig=1, then 0xDEAD_BEEF sig=2, no acks -> out0=AA, out1=12345678, out2=DEADBEEF, out_valid=111, each valid one cycle after its accept.
  - Then offer sig=1 -> in_ready=0 until out_ack[1] pulses.
- Back-to-back on a full slot: slot 0 FULL with 0x11; in the same cycle assert out_ack[0] and offer 0x22 sig=0 -> in_ready=1, next cycle out0=0x22 and out_valid[0] stays 1.
- Illegal codes:
  - Offer sig=3,5,7 with 0xFFFF_FFFF -> in_ready=1 each time, slots unchanged, drop_cnt=3.
  - Force 300 illegal accepts -> drop_cnt=255 (saturated, no wrap).
- Spurious/parallel acks:
  - out_ack=111 with all slots EMPTY -> no state change.
  - With all FULL, out_ack=101 -> out_valid=010, and out0/out2 keep their data.
- Reset mid-operation: slots FULL, with in_valid=1 sig=2 pending; assert clr -> all valid=0 and data=0. After release, the first accept to slot 2 behaves as from EMPTY.
